// File: rtl/tbb1143_bus_writer.sv
// Queues {addr,data} register writes (4 deep) and plays each out as three nibble strobes on A0/D/WR.
// Latency: pop one edge after push, WR high two edges after push; cmd_ready low only while the queue is full.
module tbb1143_bus_writer #(
  parameter int WR_PULSE = 2,
  parameter int HOLD_CYC = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       A0,
  output logic [3:0] D,
  output logic       WR,
  output logic       busy
);

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  cmd_t       fifo_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q;
  logic       push, pop;
  cmd_t       head;

  state_t     state_q, state_d;
  logic [1:0] n_q, n_d;
  logic [3:0] cnt_q, cnt_d;
  cmd_t       cmd_q, cmd_d;
  logic       a0_q, a0_d;
  logic [3:0] d_q, d_d;
  logic       wr_q, wr_d;

  function automatic logic [4:0] nibble(input cmd_t c, input logic [1:0] n);
    case (n)
      2'd0:    nibble = {1'b0, c.addr};
      2'd1:    nibble = {1'b1, c.data[3:0]};
      default: nibble = {1'b1, c.data[7:4]};
    endcase
  endfunction

  assign cmd_ready = (count_q < 3'd4);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == IDLE) && (count_q != 3'd0);
  assign head      = fifo_q[rd_ptr_q];
  assign busy      = (count_q != 3'd0) || (state_q != IDLE);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge CLK) begin
    if (RST && push) fifo_q[wr_ptr_q] <= '{addr: cmd_addr, data: cmd_data};
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    a0_d    = a0_q;
    d_d     = d_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          cmd_d       = head;
          n_d         = 2'd0;
          {a0_d, d_d} = nibble(head, 2'd0);
          state_d     = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = 4'(WR_PULSE - 1);
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = 4'(HOLD_CYC - 1);
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (n_q < 2'd2) begin
          // Bus only moves here, with WR already low for HOLD_CYC cycles.
          n_d         = n_q + 2'd1;
          {a0_d, d_d} = nibble(cmd_q, n_q + 2'd1);
          state_d     = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    wr_d = (state_d == STROBE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      n_q     <= 2'd0;
      cnt_q   <= 4'd0;
      cmd_q   <= '0;
      a0_q    <= 1'b0;
      d_q     <= 4'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      a0_q    <= a0_d;
      d_q     <= d_d;
      wr_q    <= wr_d;
    end
  end

  assign A0 = a0_q;
  assign D  = d_q;
  assign WR = wr_q;

endmodule
